// File: rtl/ofdm_cp_inserter_if.sv
// AXI-Stream channel shared by the IFFT-side input and the CP-inserted output.
// The master drives data/valid/last/keep; the slave returns ready.
interface ofdm_cp_inserter_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [3:0]        tkeep;

   modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/ofdm_cp_inserter.sv
// Buffers one IFFT symbol at a time and replays it prefixed by its last cp_len samples,
// framing `symbols` symbols with tlast on the final sample of the frame.
module ofdm_cp_inserter #(
   parameter int MAX_NFFT = 4096,
   parameter int DATA_W   = 32
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [11:0]        i_cp_len,
   input  logic [11:0]        i_nfft,
   input  logic [3:0]         i_symbols,
   ofdm_cp_inserter_if.slave  S_AXIS,
   ofdm_cp_inserter_if.master M_AXIS,
   output logic               o_busy,
   output logic               o_cfg_err
);
   typedef enum logic [1:0] {IDLE, LOAD, CP, BODY} state_t;

   state_t            state_q, state_d;
   logic [11:0]       nfft_q, nfft_d;
   logic [11:0]       cp_len_q, cp_len_d;
   logic [3:0]        symbols_q, symbols_d;
   logic [3:0]        sym_cnt_q, sym_cnt_d;
   logic [11:0]       wr_cnt_q, wr_cnt_d;
   logic [11:0]       rd_cnt_q, rd_cnt_d;
   logic              issue_done_q, issue_done_d;
   logic              busy_q, busy_d;
   logic              cfg_err_q, cfg_err_d;

   logic              cfg_legal;
   logic              s_ready;
   logic              wr_en;
   logic              pop;
   logic              can_issue;
   logic              rd_req;
   logic              rd_end;
   logic              rd_last;
   logic [1:0]        occ;
   logic [11:0]       rd_addr;
   logic [11:0]       cp_start;

   logic [DATA_W-1:0] mem [MAX_NFFT];
   logic [DATA_W-1:0] rd_data_p1_q;
   logic              rd_vld_p1_q, rd_vld_p1_d;
   logic              rd_end_p1_q, rd_end_p1_d;
   logic              rd_last_p1_q, rd_last_p1_d;

   logic              skid_vld_q, skid_vld_d;
   logic              skid_end_q, skid_end_d;
   logic              skid_last_q, skid_last_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;

   logic              out_vld_q, out_vld_d;
   logic              out_end_q, out_end_d;
   logic              out_last_q, out_last_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   logic              unused_s_axis;

   assign unused_s_axis = ^{S_AXIS.tlast, S_AXIS.tkeep};

   assign cfg_legal = (i_nfft != 12'd0) && (i_symbols != 4'd0) && (i_cp_len < i_nfft);
   assign cp_start  = nfft_q - cp_len_q;
   assign pop       = out_vld_q && M_AXIS.tready;

   // Reads in flight plus held samples never exceed the two output slots (out + skid).
   assign occ       = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_p1_q};
   assign can_issue = (occ - {1'b0, pop}) < 2'd2;

   assign S_AXIS.tready = s_ready && !areset;
   assign M_AXIS.tvalid = out_vld_q;
   assign M_AXIS.tdata  = out_data_q;
   assign M_AXIS.tlast  = out_last_q;
   assign M_AXIS.tkeep  = 4'hF;
   assign o_busy        = busy_q;
   assign o_cfg_err     = cfg_err_q;

   always_comb begin
      state_d      = state_q;
      nfft_d       = nfft_q;
      cp_len_d     = cp_len_q;
      symbols_d    = symbols_q;
      sym_cnt_d    = sym_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      issue_done_d = issue_done_q;
      busy_d       = busy_q;
      cfg_err_d    = cfg_err_q;
      s_ready      = 1'b0;
      wr_en        = 1'b0;
      rd_req       = 1'b0;
      rd_end       = 1'b0;
      rd_last      = 1'b0;
      rd_addr      = rd_cnt_q;

      case (state_q)
         IDLE: begin
            cfg_err_d = !cfg_legal;
            s_ready   = cfg_legal;
            wr_en     = s_ready && S_AXIS.tvalid;
            if (wr_en) begin
               nfft_d    = i_nfft;
               cp_len_d  = i_cp_len;
               symbols_d = i_symbols;
               busy_d    = 1'b1;
               // A one-sample symbol is complete on its first write; cp_len is then 0.
               if (i_nfft == 12'd1) begin
                  wr_cnt_d = 12'd0;
                  state_d  = BODY;
               end else begin
                  wr_cnt_d = 12'd1;
                  state_d  = LOAD;
               end
            end
         end

         LOAD: begin
            s_ready = 1'b1;
            wr_en   = S_AXIS.tvalid;
            if (wr_en) begin
               if (wr_cnt_q == nfft_q - 12'd1) begin
                  wr_cnt_d = 12'd0;
                  state_d  = (cp_len_q != 12'd0) ? CP : BODY;
               end else begin
                  wr_cnt_d = wr_cnt_q + 12'd1;
               end
            end
         end

         CP: begin
            rd_addr = cp_start + rd_cnt_q;
            rd_req  = can_issue;
            if (rd_req) begin
               if (rd_cnt_q == cp_len_q - 12'd1) begin
                  rd_cnt_d = 12'd0;
                  state_d  = BODY;
               end else begin
                  rd_cnt_d = rd_cnt_q + 12'd1;
               end
            end
         end

         BODY: begin
            rd_req = can_issue && !issue_done_q;
            if (rd_req) begin
               if (rd_cnt_q == nfft_q - 12'd1) begin
                  rd_end       = 1'b1;
                  rd_last      = (sym_cnt_q == symbols_q - 4'd1);
                  rd_cnt_d     = 12'd0;
                  issue_done_d = 1'b1;
               end else begin
                  rd_cnt_d = rd_cnt_q + 12'd1;
               end
            end
            // The buffer is reloaded only once the symbol's final sample has left.
            if (pop && out_end_q) begin
               issue_done_d = 1'b0;
               if (sym_cnt_q + 4'd1 == symbols_q) begin
                  sym_cnt_d = 4'd0;
                  busy_d    = 1'b0;
                  state_d   = IDLE;
               end else begin
                  sym_cnt_d = sym_cnt_q + 4'd1;
                  state_d   = LOAD;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // p1: buffer read data arrives one cycle after the request
   always_comb begin
      rd_vld_p1_d  = rd_req;
      rd_end_p1_d  = rd_end;
      rd_last_p1_d = rd_last;
   end

   // p2: output register with a one-entry skid so a stalled sink loses nothing
   always_comb begin
      out_vld_d   = out_vld_q;
      out_end_d   = out_end_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      skid_vld_d  = skid_vld_q;
      skid_end_d  = skid_end_q;
      skid_last_d = skid_last_q;
      skid_data_d = skid_data_q;

      if (!out_vld_q || pop) begin
         if (skid_vld_q) begin
            out_vld_d   = 1'b1;
            out_end_d   = skid_end_q;
            out_last_d  = skid_last_q;
            out_data_d  = skid_data_q;
            skid_vld_d  = rd_vld_p1_q;
            skid_end_d  = rd_end_p1_q;
            skid_last_d = rd_last_p1_q;
            skid_data_d = rd_data_p1_q;
         end else if (rd_vld_p1_q) begin
            out_vld_d  = 1'b1;
            out_end_d  = rd_end_p1_q;
            out_last_d = rd_last_p1_q;
            out_data_d = rd_data_p1_q;
         end else begin
            out_vld_d  = 1'b0;
            out_end_d  = 1'b0;
            out_last_d = 1'b0;
         end
      end else if (rd_vld_p1_q) begin
         skid_vld_d  = 1'b1;
         skid_end_d  = rd_end_p1_q;
         skid_last_d = rd_last_p1_q;
         skid_data_d = rd_data_p1_q;
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_cnt_q] <= S_AXIS.tdata;
      if (rd_req) rd_data_p1_q <= mem[rd_addr];
      skid_data_q <= skid_data_d;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= IDLE;
         nfft_q       <= '0;
         cp_len_q     <= '0;
         symbols_q    <= '0;
         sym_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         issue_done_q <= 1'b0;
         busy_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         rd_vld_p1_q  <= 1'b0;
         rd_end_p1_q  <= 1'b0;
         rd_last_p1_q <= 1'b0;
         skid_vld_q   <= 1'b0;
         skid_end_q   <= 1'b0;
         skid_last_q  <= 1'b0;
         out_vld_q    <= 1'b0;
         out_end_q    <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         nfft_q       <= nfft_d;
         cp_len_q     <= cp_len_d;
         symbols_q    <= symbols_d;
         sym_cnt_q    <= sym_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         issue_done_q <= issue_done_d;
         busy_q       <= busy_d;
         cfg_err_q    <= cfg_err_d;
         rd_vld_p1_q  <= rd_vld_p1_d;
         rd_end_p1_q  <= rd_end_p1_d;
         rd_last_p1_q <= rd_last_p1_d;
         skid_vld_q   <= skid_vld_d;
         skid_end_q   <= skid_end_d;
         skid_last_q  <= skid_last_d;
         out_vld_q    <= out_vld_d;
         out_end_q    <= out_end_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
      end
   end
endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Scoreboard bench for ofdm_cp_inserter: stimulus pushes the expected CP+body stream,
// an independent monitor pops and compares every output handshake.
module tb_ofdm_cp_inserter;
   logic        aclk = 1'b0;
   logic        areset;
   logic [11:0] i_cp_len;
   logic [11:0] i_nfft;
   logic [3:0]  i_symbols;
   logic        o_busy;
   logic        o_cfg_err;

   ofdm_cp_inserter_if #(.DATA_W(32)) s_if ();
   ofdm_cp_inserter_if #(.DATA_W(32)) m_if ();

   ofdm_cp_inserter #(.MAX_NFFT(4096), .DATA_W(32)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .i_cp_len  (i_cp_len),
      .i_nfft    (i_nfft),
      .i_symbols (i_symbols),
      .S_AXIS    (s_if),
      .M_AXIS    (m_if),
      .o_busy    (o_busy),
      .o_cfg_err (o_cfg_err)
   );

   always #5 aclk = ~aclk;

   int          n_chk = 0;
   int          n_err = 0;
   int          n_out = 0;
   bit          rdy_rand = 1'b0;
   logic [32:0] exp_q[$];
   logic [31:0] sym_buf [4096];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sink ready: steady or coin-flip, changed just after each active edge.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: values seen at a falling edge are what the next rising edge samples.
   bit          stall_v = 1'b0;
   bit          busy_chk = 1'b0;
   logic [32:0] stall_val;
   always @(negedge aclk) begin
      if (areset) begin
         stall_v  = 1'b0;
         busy_chk = 1'b0;
      end else begin
         if (busy_chk) begin
            chk("busy_fall_after_tlast", 64'(o_busy), 64'(0));
            busy_chk = 1'b0;
         end
         if (stall_v) begin
            chk("stall_hold", 64'({m_if.tvalid, m_if.tlast, m_if.tdata}), 64'({1'b1, stall_val}));
            stall_v = 1'b0;
         end
         if (m_if.tvalid) begin
            chk("s_ready_blocked", 64'(s_if.tready), 64'(0));
            if (m_if.tready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", 64'({m_if.tlast, m_if.tdata}), 64'(0));
               end else begin
                  logic [32:0] e;
                  e = exp_q.pop_front();
                  chk("out_sample", 64'({m_if.tlast, m_if.tdata}), 64'(e));
                  n_out++;
                  if (e[32]) busy_chk = 1'b1;
               end
            end else begin
               stall_v   = 1'b1;
               stall_val = {m_if.tlast, m_if.tdata};
            end
         end
      end
   end

   task automatic set_cfg(input int nfft, input int cp, input int nsym);
      i_nfft    = 12'(nfft);
      i_cp_len  = 12'(cp);
      i_symbols = 4'(nsym);
   endtask

   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic send(input logic [31:0] d);
      int n = 0;
      s_if.tdata  = d;
      s_if.tvalid = 1'b1;
      while (!s_if.tready && n < 20000) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 20000) chk("send_timeout", 64'(1), 64'(0));
      @(negedge aclk);
      s_if.tvalid = 1'b0;
   endtask

   task automatic send_symbol(input int s, input int nfft, input int cp, input int nsym,
                              input bit rnd, input int base, input bit lat_chk, input bit scramble);
      int k;
      for (int i = 0; i < nfft; i++) begin
         sym_buf[i] = rnd ? $urandom : 32'(base + s * 100 + i);
         send(sym_buf[i]);
         if (scramble && s == 0 && i == 0) set_cfg(5, 3, 1);
      end
      for (int j = nfft - cp; j < nfft; j++) exp_q.push_back({1'b0, sym_buf[j]});
      for (int j = 0; j < nfft; j++)
         exp_q.push_back({(s == nsym - 1) && (j == nfft - 1), sym_buf[j]});
      if (lat_chk && s == 0) begin
         k = 0;
         while (!m_if.tvalid && k < 8) begin
            @(negedge aclk);
            k++;
         end
         chk("first_cp_latency", 64'(k), 64'(2));
      end
   endtask

   task automatic wait_drain(input int bound);
      int k = 0;
      while ((exp_q.size() != 0 || o_busy || m_if.tvalid) && k < bound) begin
         @(negedge aclk);
         k++;
      end
      chk("drain_timeout", 64'(k >= bound), 64'(0));
      @(negedge aclk);
   endtask

   task automatic run_frame(input int nfft, input int cp, input int nsym, input bit rnd,
                            input int base, input bit lat_chk, input bit scramble);
      set_cfg(nfft, cp, nsym);
      @(negedge aclk);
      for (int s = 0; s < nsym; s++) send_symbol(s, nfft, cp, nsym, rnd, base, lat_chk, scramble);
      set_cfg(nfft, cp, nsym);
      wait_drain(20000);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int base_n;
      areset      = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      s_if.tkeep  = 4'hF;
      set_cfg(16, 4, 2);
      repeat (3) @(negedge aclk);

      chk("rst_tvalid",  64'(m_if.tvalid), 64'(0));
      chk("rst_tdata",   64'(m_if.tdata),  64'(0));
      chk("rst_tlast",   64'(m_if.tlast),  64'(0));
      chk("rst_tkeep",   64'(m_if.tkeep),  64'(4'hF));
      chk("rst_busy",    64'(o_busy),      64'(0));
      chk("rst_cfg_err", 64'(o_cfg_err),   64'(0));
      chk("rst_s_ready", 64'(s_if.tready), 64'(0));
      areset = 1'b0;
      @(negedge aclk);
      chk("idle_s_ready", 64'(s_if.tready), 64'(1));

      // Nominal frame with config ports disturbed after the first sample.
      run_frame(16, 4, 2, 1'b0, 0, 1'b1, 1'b1);
      chk("nominal_count", 64'(n_out), 64'(40));

      // Random backpressure on the output.
      rdy_rand = 1'b1;
      base_n = n_out;
      run_frame(16, 4, 2, 1'b0, 0, 1'b1, 1'b0);
      rdy_rand = 1'b0;
      chk("backpressure_count", 64'(n_out - base_n), 64'(40));

      // No cyclic prefix.
      base_n = n_out;
      run_frame(8, 0, 1, 1'b0, 0, 1'b0, 1'b0);
      chk("cp0_count", 64'(n_out - base_n), 64'(8));

      // Illegal configurations: offered samples must be refused.
      for (int c = 0; c < 3; c++) begin
         if (c == 0) set_cfg(16, 16, 2);
         else if (c == 1) set_cfg(0, 0, 2);
         else set_cfg(16, 4, 0);
         s_if.tvalid = 1'b1;
         s_if.tdata  = 32'hDEAD_0000 + 32'(c);
         repeat (3) @(negedge aclk);
         chk("illegal_cfg_err", 64'(o_cfg_err),   64'(1));
         chk("illegal_s_ready", 64'(s_if.tready), 64'(0));
         chk("illegal_busy",    64'(o_busy),      64'(0));
         chk("illegal_tvalid",  64'(m_if.tvalid), 64'(0));
      end
      s_if.tvalid = 1'b0;
      set_cfg(16, 4, 2);
      @(negedge aclk);
      chk("legal_cfg_err_clear", 64'(o_cfg_err), 64'(0));
      base_n = n_out;
      run_frame(16, 4, 2, 1'b0, 0, 1'b0, 1'b0);
      chk("after_illegal_count", 64'(n_out - base_n), 64'(40));

      // Reset in the body of symbol 1, then a clean frame.
      set_cfg(16, 4, 2);
      @(negedge aclk);
      base_n = n_out;
      send_symbol(0, 16, 4, 2, 1'b0, 200, 1'b0, 1'b0);
      send_symbol(1, 16, 4, 2, 1'b0, 200, 1'b0, 1'b0);
      k = 0;
      while (n_out < base_n + 30 && k < 500) begin
         @(negedge aclk);
         k++;
      end
      chk("reach_body_sym1", 64'(k >= 500), 64'(0));
      areset = 1'b1;
      #1;
      chk("midrst_tvalid", 64'(m_if.tvalid), 64'(0));
      chk("midrst_busy",   64'(o_busy),      64'(0));
      chk("midrst_tlast",  64'(m_if.tlast),  64'(0));
      exp_q.delete();
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      base_n = n_out;
      run_frame(16, 4, 2, 1'b0, 0, 1'b0, 1'b0);
      chk("post_reset_count", 64'(n_out - base_n), 64'(40));

      // Largest expressible symbol with random data.
      base_n = n_out;
      run_frame(4095, 256, 2, 1'b1, 0, 1'b1, 1'b0);
      chk("full_size_count", 64'(n_out - base_n), 64'(2 * (4095 + 256)));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
